// File: rtl/dphy_rx_lane_if.sv
// Lane bundle between the HS/LP front end and the D-PHY receive lane.
// The master drives the raw LP pair and HS bytes. The slave (the lane) returns aligned data and status.
interface dphy_rx_lane_if;
  logic [1:0] lp_in;
  logic [7:0] hs_byte;
  logic       hs_term_en;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       sot;
  logic       eot;
  logic       sync_err;
  logic       lp_err;
  logic [1:0] lp_state;

  modport master (
    output lp_in, hs_byte,
    input  hs_term_en, byte_out, byte_valid, sot, eot, sync_err, lp_err, lp_state
  );

  modport slave (
    input  lp_in, hs_byte,
    output hs_term_en, byte_out, byte_valid, sot, eot, sync_err, lp_err, lp_state
  );
endinterface

// File: rtl/dphy_rx_lane.sv
// Single-lane D-PHY receiver: filters the LP pair and detects HS entry.
// It then hunts the leader byte at any bit offset and streams byte-aligned payload with SoT/EoT.
module dphy_rx_lane #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8,
  parameter int unsigned LP_FILTER    = 3,
  parameter int unsigned HS_SETTLE    = 4,
  parameter int unsigned SYNC_TIMEOUT = 32
) (
  input logic           byte_clk,
  input logic           reset,
  dphy_rx_lane_if.slave lane
);

  localparam int unsigned FiltW = $clog2(LP_FILTER + 1);
  localparam int unsigned CntW  = $clog2(SYNC_TIMEOUT + HS_SETTLE + 1);

  localparam logic [1:0] LpStop   = 2'b11;
  localparam logic [1:0] LpRqst   = 2'b01;
  localparam logic [1:0] LpBridge = 2'b00;
  localparam logic [1:0] LpEsc    = 2'b10;

  typedef enum logic [2:0] {
    StWaitStop, StStop, StHsRqst, StSettle, StHunt, StReceive
  } state_e;

  state_e           state_q;
  logic [1:0]       lp_s1_q, lp_s2_q, lp_cand_q, lp_state_q, lp_state_d;
  logic [FiltW-1:0] lp_cnt_q, lp_cnt_d;
  logic [7:0]       prev_hs_q;
  logic [15:0]      win;
  logic             match_any;
  logic [2:0]       match_k;
  logic [2:0]       offset_q;
  logic [CntW-1:0]  cnt_q;
  logic [7:0]       pay_q, byte_out_q;
  logic             pay_vld_q, byte_valid_q;
  logic             term_q, sot_q, eot_q, sync_err_q, lp_err_q;

  // A new LP level is accepted only after LP_FILTER identical synchronized samples.
  always_comb begin
    if (lp_s2_q == lp_cand_q) begin
      lp_cnt_d = (lp_cnt_q == FiltW'(LP_FILTER)) ? lp_cnt_q : lp_cnt_q + 1'b1;
    end else begin
      lp_cnt_d = FiltW'(1);
    end
    lp_state_d = (lp_cnt_d == FiltW'(LP_FILTER)) ? lp_s2_q : lp_state_q;
  end

  always_ff @(posedge byte_clk) begin
    if (reset) begin
      lp_s1_q    <= 2'b00;
      lp_s2_q    <= 2'b00;
      lp_cand_q  <= 2'b00;
      lp_cnt_q   <= '0;
      lp_state_q <= 2'b00;
      prev_hs_q  <= 8'h00;
    end else begin
      lp_s1_q    <= lane.lp_in;
      lp_s2_q    <= lp_s1_q;
      lp_cand_q  <= lp_s2_q;
      lp_cnt_q   <= lp_cnt_d;
      lp_state_q <= lp_state_d;
      prev_hs_q  <= lane.hs_byte;
    end
  end

  // Descending scan so the lowest matching offset is the one that sticks.
  always_comb begin
    win       = {lane.hs_byte, prev_hs_q};
    match_any = 1'b0;
    match_k   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (win[k +: 8] == SYNC_BYTE) begin
        match_any = 1'b1;
        match_k   = 3'(k);
      end
    end
  end

  always_ff @(posedge byte_clk) begin
    if (reset) begin
      state_q      <= StWaitStop;
      offset_q     <= 3'd0;
      cnt_q        <= '0;
      pay_q        <= 8'h00;
      pay_vld_q    <= 1'b0;
      byte_out_q   <= 8'h00;
      byte_valid_q <= 1'b0;
      term_q       <= 1'b0;
      sot_q        <= 1'b0;
      eot_q        <= 1'b0;
      sync_err_q   <= 1'b0;
      lp_err_q     <= 1'b0;
    end else begin
      sot_q        <= 1'b0;
      eot_q        <= 1'b0;
      sync_err_q   <= 1'b0;
      lp_err_q     <= 1'b0;
      pay_vld_q    <= 1'b0;
      pay_q        <= win[offset_q +: 8];
      byte_out_q   <= pay_q;
      byte_valid_q <= pay_vld_q;
      unique case (state_q)
        StWaitStop: if (lp_state_q == LpStop) state_q <= StStop;
        StStop: begin
          if (lp_state_q == LpRqst) begin
            state_q <= StHsRqst;
          end else if (lp_state_q != LpStop) begin
            lp_err_q <= 1'b1;
            state_q  <= StWaitStop;
          end
        end
        StHsRqst: begin
          if (lp_state_q == LpBridge) begin
            state_q <= StSettle;
            cnt_q   <= '0;
            term_q  <= 1'b1;
          end else if (lp_state_q == LpStop) begin
            state_q <= StStop;
          end else if (lp_state_q == LpEsc) begin
            lp_err_q <= 1'b1;
            state_q  <= StWaitStop;
          end
        end
        StSettle: begin
          if (lp_state_q == LpStop) begin
            state_q <= StStop;
            term_q  <= 1'b0;
          end else if (cnt_q == CntW'(HS_SETTLE - 1)) begin
            state_q <= StHunt;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHunt: begin
          if (lp_state_q == LpStop) begin
            state_q <= StStop;
            term_q  <= 1'b0;
          end else if (match_any) begin
            offset_q <= match_k;
            sot_q    <= 1'b1;
            state_q  <= StReceive;
          end else if (cnt_q == CntW'(SYNC_TIMEOUT - 1)) begin
            sync_err_q <= 1'b1;
            state_q    <= StWaitStop;
            term_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StReceive: begin
          // Byte in flight in the pay stage is dropped; it can only be trailer.
          if (lp_state_q == LpStop) begin
            eot_q        <= 1'b1;
            byte_valid_q <= 1'b0;
            state_q      <= StStop;
            term_q       <= 1'b0;
          end else begin
            pay_vld_q <= 1'b1;
          end
        end
        default: state_q <= StWaitStop;
      endcase
    end
  end

  assign lane.hs_term_en = term_q;
  assign lane.byte_out   = byte_out_q;
  assign lane.byte_valid = byte_valid_q;
  assign lane.sot        = sot_q;
  assign lane.eot        = eot_q;
  assign lane.sync_err   = sync_err_q;
  assign lane.lp_err     = lp_err_q;
  assign lane.lp_state   = lp_state_q;

endmodule

// File: tb/tb_dphy_rx_lane.sv
// Bench for dphy_rx_lane: builds HS bursts as plain bit streams with the leader at a chosen offset.
// Every delivered byte is predicted directly from those streams.
module tb_dphy_rx_lane;

  logic byte_clk = 1'b0;
  logic reset;
  always #5 byte_clk = ~byte_clk;

  dphy_rx_lane_if bus ();

  dphy_rx_lane #(
    .SYNC_BYTE   (8'hB8),
    .LP_FILTER   (3),
    .HS_SETTLE   (4),
    .SYNC_TIMEOUT(32)
  ) dut (
    .byte_clk(byte_clk),
    .reset   (reset),
    .lane    (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  int cyc_n, sot_n, eot_n, serr_n, lperr_n, term_n, term_last, serr_cyc;
  int sot_cyc, vld_cyc, eot_vld_n, post_eot_vld_n, long_n, bad_lp_n;
  logic       eot_seen;
  logic [3:0] prev_pulses;
  logic [7:0] got[$];
  logic [7:0] pl[$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    cyc_n = 0; sot_n = 0; eot_n = 0; serr_n = 0; lperr_n = 0; term_n = 0;
    term_last = -1; serr_cyc = -1; sot_cyc = -1; vld_cyc = -1;
    eot_vld_n = 0; post_eot_vld_n = 0; long_n = 0; bad_lp_n = 0;
    eot_seen = 1'b0; prev_pulses = 4'b0000;
    got.delete();
  endtask

  task automatic sample();
    logic [3:0] pulses;
    cyc_n++;
    if (bus.sot) begin sot_n++; sot_cyc = cyc_n; end
    if (bus.byte_valid) begin
      if (vld_cyc < 0) vld_cyc = cyc_n;
      got.push_back(bus.byte_out);
      if (eot_seen) post_eot_vld_n++;
    end
    if (bus.eot) begin
      eot_n++;
      eot_seen = 1'b1;
      if (bus.byte_valid) eot_vld_n++;
    end
    if (bus.sync_err) begin serr_n++; serr_cyc = cyc_n; end
    if (bus.lp_err) lperr_n++;
    if (bus.hs_term_en) begin term_n++; term_last = cyc_n; end
    if (bus.lp_state != 2'b11) bad_lp_n++;
    pulses = {bus.sot, bus.eot, bus.sync_err, bus.lp_err};
    if ((pulses & prev_pulses) != 4'b0000) long_n++;
    prev_pulses = pulses;
  endtask

  // Inputs change just after posedge; outputs are sampled on the negedge.
  task automatic cycle(input logic [1:0] lp, input logic [7:0] hs);
    bus.lp_in   = lp;
    bus.hs_byte = hs;
    @(negedge byte_clk);
    sample();
    @(posedge byte_clk);
    #1;
  endtask

  task automatic burst(input string tag, input int k, input logic [7:0] pay[$], input bit abort);
    bit         bits[$];
    logic [7:0] strm[$];
    logic [7:0] lead;
    logic [7:0] b8;
    logic [7:0] e;
    int         p, base, nb;
    lead = 8'hB8;
    clr_mon();
    repeat (10) cycle(2'b11, 8'h00);
    repeat (8) cycle(2'b01, 8'h00);
    for (int i = 0; i < 16 * 8 + k; i++) bits.push_back(1'b0);
    p = bits.size();
    for (int i = 0; i < 8; i++) bits.push_back(lead[i]);
    foreach (pay[j]) begin
      b8 = pay[j];
      for (int i = 0; i < 8; i++) bits.push_back(b8[i]);
    end
    for (int j = 0; j < 24; j++) begin
      b8 = 8'($urandom);
      for (int i = 0; i < 8; i++) bits.push_back(b8[i]);
    end
    while (bits.size() % 8 != 0) bits.push_back(1'b0);
    nb = bits.size() / 8;
    for (int j = 0; j < nb; j++) begin
      for (int i = 0; i < 8; i++) b8[i] = bits[8 * j + i];
      strm.push_back(b8);
    end
    for (int j = 0; j < nb; j++) begin
      cycle((j < nb - 12) ? 2'b00 : 2'b11, strm[j]);
      if (abort && got.size() >= 2) begin
        reset = 1'b1;
        cycle(2'b00, 8'h00);
        reset = 1'b0;
        chk({tag, "_rst_outs"}, int'({bus.hs_term_en, bus.byte_out, bus.byte_valid, bus.sot,
                                      bus.eot, bus.sync_err, bus.lp_err, bus.lp_state}), 0);
        clr_mon();
        for (int i = 0; i < 12; i++) cycle(2'b00, 8'($urandom));
        chk({tag, "_rst_eot"}, eot_n, 0);
        chk({tag, "_rst_vld"}, got.size(), 0);
        chk({tag, "_rst_term"}, term_n, 0);
        return;
      end
    end
    repeat (10) cycle(2'b11, 8'h00);
    chk({tag, "_sot"}, sot_n, 1);
    chk({tag, "_eot"}, eot_n, 1);
    chk({tag, "_errs"}, serr_n + lperr_n, 0);
    chk({tag, "_lat"}, vld_cyc - sot_cyc, 2);
    chk({tag, "_eot_vld"}, eot_vld_n + post_eot_vld_n, 0);
    chk({tag, "_count"}, int'(got.size() >= pay.size()), 1);
    chk({tag, "_pulse"}, long_n, 0);
    foreach (got[i]) begin
      base = p + 8 + 8 * i;
      e = 8'h00;
      for (int b = 0; b < 8; b++) e[b] = (base + b < bits.size()) ? bits[base + b] : 1'b0;
      chk($sformatf("%s_byte%0d", tag, i), int'(got[i]), int'(e));
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.lp_in   = 2'b00;
    bus.hs_byte = 8'h00;
    clr_mon();
    repeat (3) cycle(2'b11, 8'h00);
    chk("reset_outs", int'({bus.hs_term_en, bus.byte_out, bus.byte_valid, bus.sot, bus.eot,
                             bus.sync_err, bus.lp_err}), 0);
    chk("reset_lp_state", int'(bus.lp_state), 0);
    reset = 1'b0;

    pl = '{8'h01, 8'h02, 8'h03};
    burst("t1", 0, pl, 1'b0);
    pl = '{8'hA5, 8'h3C};
    burst("t2", 5, pl, 1'b0);
    chk("t2_offset", int'(dut.offset_q), 5);

    for (int r = 0; r < 3; r++) begin
      pl.delete();
      repeat ($urandom_range(12, 4)) pl.push_back(8'($urandom));
      burst($sformatf("rnd%0d", r), int'($urandom_range(7, 0)), pl, 1'b0);
    end

    // Hunt with no leader ever present.
    clr_mon();
    repeat (10) cycle(2'b11, 8'h00);
    repeat (8) cycle(2'b01, 8'h00);
    repeat (50) cycle(2'b00, 8'h00);
    chk("to_serr", serr_n, 1);
    chk("to_term_len", term_n, 4 + 32);
    chk("to_serr_at_drop", serr_cyc - term_last, 1);
    chk("to_no_vld", got.size(), 0);
    chk("to_no_sot", sot_n, 0);
    repeat (10) cycle(2'b11, 8'h00);
    chk("to_no_eot", eot_n, 0);
    pl = '{8'h5A, 8'hC3, 8'h99, 8'h0F};
    burst("to_rec", int'($urandom_range(7, 0)), pl, 1'b0);

    // Escape entry from STOP.
    clr_mon();
    repeat (10) cycle(2'b11, 8'h00);
    repeat (10) cycle(2'b10, 8'h00);
    chk("esc_lp_err", lperr_n, 1);
    repeat (10) cycle(2'b01, 8'h00);
    repeat (10) cycle(2'b00, 8'h00);
    chk("esc_no_term", term_n, 0);
    chk("esc_err_once", lperr_n, 1);

    clr_mon();
    repeat (10) cycle(2'b11, 8'h00);
    repeat (10) cycle(2'b00, 8'h00);
    chk("stop00_lp_err", lperr_n, 1);
    chk("stop00_no_term", term_n, 0);

    clr_mon();
    repeat (10) cycle(2'b11, 8'h00);
    repeat (10) cycle(2'b01, 8'h00);
    repeat (10) cycle(2'b10, 8'h00);
    chk("rqst10_lp_err", lperr_n, 1);
    chk("rqst10_no_term", term_n, 0);

    pl.delete();
    repeat (6) pl.push_back(8'($urandom));
    burst("esc_rec", int'($urandom_range(7, 0)), pl, 1'b0);

    // Single-cycle glitch must never reach the filtered state.
    repeat (10) cycle(2'b11, 8'h00);
    clr_mon();
    cycle(2'b01, 8'h00);
    repeat (12) cycle(2'b11, 8'h00);
    chk("glitch_lp_state", bad_lp_n, 0);
    chk("glitch_no_term", term_n, 0);
    chk("glitch_no_err", lperr_n, 0);

    pl.delete();
    repeat (8) pl.push_back(8'($urandom));
    burst("abort", int'($urandom_range(7, 0)), pl, 1'b1);
    pl.delete();
    repeat (7) pl.push_back(8'($urandom));
    burst("fresh", int'($urandom_range(7, 0)), pl, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
